neural_param_loader: RTL and testbench
======================================

# neural_param_loader

Sequential front-end for the 2-input/2-output structural neural stage. Accepts a serial stream of ten 16-bit signed 8.8 fixed-point words (two inputs, eight weights) over a valid/ready handshake and assembles them in a shadow bank. It then atomically commits the complete frame to an active register bank that drives the neural stage's inputA/inputB/c111..c222 ports. Downstream sees parameters change only on whole-frame boundaries, never mid-frame.

## Interface
- DATA_W, 16, word width (signed fixed point)
- FRAC_W, 8, fractional bits; 1.0 = 1 << FRAC_W (16'h0100)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  DATA_W  stream word
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  loader can accept a word
- clr  in  1  synchronous frame abort
- out_ready  in  1  downstream has consumed the current active frame
- out_valid  out  1  active bank holds an unconsumed frame
- in_a, in_b  out  DATA_W each  active inputs
- c111, c112, c121, c122, c211, c212, c221, c222  out  DATA_W each  active weights
- word_idx  out  4  index of next shadow slot, 0..9

## Operation
- Stream order by index:
  - 0 = in_a, 1 = in_b
  - 2..9 = c111, c112, c121, c122, c211, c212, c221, c222
- Accept = wr_valid && wr_ready. Each accept writes shadow[word_idx] and increments word_idx.
- "Active free" = !out_valid || out_ready.
- States:
  - LOAD: wr_ready = 1.
    - Accept at idx 0..8: store the word, idx+1.
    - Accept at idx 9, active free: commit shadow plus this word into the active bank on the same edge; out_valid <= 1; idx <= 0; stay in LOAD.
    - Accept at idx 9, active not free: store the word, go to FULL.
  - FULL: wr_ready = 0; idx reads 10.
    - On out_ready: commit, out_valid stays 1, idx <= 0, go to LOAD.
- out_valid clears on out_ready only when no commit occurs on that edge. Commit and out_ready on the same edge leave out_valid = 1 with the new frame.
- clr has priority over accept and commit:
  - idx <= 0, state <= LOAD, shadow contents discarded.
  - Active bank and out_valid are untouched, except that out_ready is still honoured on that edge.
- Shadow slots are not cleared between frames. A frame always overwrites all ten slots before it can commit.
- Active outputs change only at a commit edge.

## Timing
- Reset value: all active outputs 0, out_valid 0, word_idx 0, state LOAD, wr_ready 1 (from state), shadow 0.
- Reset asserted mid-frame aborts it immediately, asynchronously. After release the loader expects word 0.
- Latency: the last word accepted at edge N appears on the active outputs and out_valid after edge N, with zero bubble.
- Throughput: one word per cycle. Back-to-back frames sustain 10 cycles/frame while out_ready is held 1.
- In FULL, wr_ready is low from the edge after the 10th accept until the cycle after the commit edge.
- wr_ready is combinational from state only; it never depends on wr_valid.

## Configuration
- NEURAL_PARAM_CLAMP_EN defined:
  - Weight words (idx 2..9) are saturated to [-(1<<FRAC_W), +(1<<FRAC_W)], i.e. 16'hFF00..16'h0100 signed, on entry to the shadow bank.
  - Input words (idx 0, 1) are passed unchanged.
- NEURAL_PARAM_CLAMP_EN undefined: all words are stored verbatim.

## Test plan
- Reset: drive rst_n low mid-stream (idx 5) -> all outputs 0, out_valid 0, word_idx 0 immediately. After release the next word lands in in_a.
- Single frame: ten words 16'h0100 with out_ready 0 -> after the 10th accept all outputs = 16'h0100, out_valid 1, wr_ready stays 1, word_idx 0.
- Backpressure:
  - Send a second frame of 16'h0000 with out_ready 0 -> FULL, wr_ready 0, outputs still 16'h0100.
  - Pulse out_ready one cycle -> outputs 16'h0000, out_valid 1, wr_ready 1 the next cycle.
- Abort: send 4 words 16'h0200, pulse clr, then ten words 16'h0100 -> committed frame is all 16'h0100. Active bank is unchanged during the abort.
- Simultaneous: out_ready high on the same edge as the 10th accept -> out_valid stays 1 and shows the new frame. With no further frame, the next out_ready drops out_valid to 0.
- Clamp: words 16'h0300 and 16'hF000 at c111/c112, 16'h0300 at in_a -> with NEURAL_PARAM_CLAMP_EN, c111 = 16'h0100, c112 = 16'hFF00, in_a = 16'h0300. Without the macro, c111 = 16'h0300, c112 = 16'hF000.

Source files
------------

// File: rtl/neural_param_loader.sv
// neural_param_loader
// Collects ten 8.8 fixed-point words (in_a, in_b, then eight weights) from a
// valid/ready stream into a shadow bank. A finished frame is copied into the
// active bank in one step, so the neural stage only ever sees whole frames.
// Optional build macro: NEURAL_PARAM_CLAMP_EN saturates weight words to
// [-1.0, +1.0] as they enter the shadow bank. Input words are never clamped.
module neural_param_loader #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] in_a,
  output logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] c111,
  output logic [DATA_W-1:0] c112,
  output logic [DATA_W-1:0] c121,
  output logic [DATA_W-1:0] c122,
  output logic [DATA_W-1:0] c211,
  output logic [DATA_W-1:0] c212,
  output logic [DATA_W-1:0] c221,
  output logic [DATA_W-1:0] c222,
  output logic [3:0]        word_idx
);

  localparam int         NWORDS   = 10;
  localparam logic [3:0] LAST_IDX = 4'd9;

  // LOAD accepts words; FULL holds a complete frame waiting for the active bank
  typedef enum logic {
    LOAD,
    FULL
  } state_t;

  state_t state, state_next;

  logic [3:0]        idx;
  logic [DATA_W-1:0] shadow       [NWORDS];
  logic [DATA_W-1:0] active       [NWORDS];
  logic [DATA_W-1:0] commit_frame [NWORDS];
  logic [DATA_W-1:0] wr_word;
  logic              accept;
  logic              store;
  logic              commit;
  logic              active_free;

`ifdef NEURAL_PARAM_CLAMP_EN
  localparam logic signed [DATA_W-1:0] POS_ONE = DATA_W'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] NEG_ONE = -POS_ONE;

  function automatic logic [DATA_W-1:0] sat_weight(input logic [DATA_W-1:0] w);
    logic signed [DATA_W-1:0] s;
    s = $signed(w);
    if (s > POS_ONE)      return POS_ONE;
    else if (s < NEG_ONE) return NEG_ONE;
    else                  return w;
  endfunction

  // Weights (slots 2..9) are saturated on their way into the shadow bank
  assign wr_word = (idx >= 4'd2) ? sat_weight(wr_data) : wr_data;
`else
  assign wr_word = wr_data;
`endif

  assign active_free = !out_valid || out_ready;
  assign word_idx    = (state == FULL) ? 4'd10 : idx;

  // Next-state and handshake decode; clr overrides both storing and committing
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    accept     = 1'b0;
    store      = 1'b0;
    commit     = 1'b0;
    case (state)
      LOAD: begin
        wr_ready = 1'b1;
        accept   = wr_valid;
        if (accept) begin
          store = 1'b1;
          if (idx == LAST_IDX) begin
            if (active_free) commit = 1'b1;
            else             state_next = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          commit     = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
    if (clr) begin
      state_next = LOAD;
      store      = 1'b0;
      commit     = 1'b0;
    end
  end

  // A commit from LOAD takes the last word straight from the stream
  always_comb begin
    for (int i = 0; i < NWORDS - 1; i++) commit_frame[i] = shadow[i];
    commit_frame[NWORDS-1] = (state == FULL) ? shadow[NWORDS-1] : wr_word;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Shadow slot pointer wraps to 0 after the tenth word or on an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (store) begin
      idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    end
  end

  // Shadow bank write; slots are only overwritten, never cleared between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NWORDS; i++)
        if (store && idx == i[3:0]) shadow[i] <= wr_word;
    end
  end

  // Active bank changes only on a commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) active[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NWORDS; i++) active[i] <= commit_frame[i];
    end
  end

  // A commit keeps out_valid high even when the old frame is consumed that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_valid <= 1'b0;
    else if (commit)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  assign in_a = active[0];
  assign in_b = active[1];
  assign c111 = active[2];
  assign c112 = active[3];
  assign c121 = active[4];
  assign c122 = active[5];
  assign c211 = active[6];
  assign c212 = active[7];
  assign c221 = active[8];
  assign c222 = active[9];

endmodule

// File: tb/tb_neural_param_loader.sv
// Testbench for neural_param_loader: a frame-level queue model checked on
// every falling edge, plus directed literal checks at key points.
// Honours NEURAL_PARAM_CLAMP_EN the same way as the design build.
module tb_neural_param_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        clr;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] in_a, in_b, c111, c112, c121, c122, c211, c212, c221, c222;
  logic [3:0]  word_idx;

  int assertions = 0;
  int failures   = 0;

  neural_param_loader #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .clr(clr), .out_ready(out_ready), .out_valid(out_valid),
    .in_a(in_a), .in_b(in_b),
    .c111(c111), .c112(c112), .c121(c121), .c122(c122),
    .c211(c211), .c212(c212), .c221(c221), .c222(c222),
    .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  // Model state: words of the frame in progress, a parked full frame, the active frame
  logic [15:0] partial[$];
  logic [15:0] pending[$];
  logic [15:0] mact[10];
  bit          mvalid;
  bit          macc;
  bit          mcommit;
  logic [15:0] mframe[10];

  function automatic logic [15:0] modelWord(input logic [15:0] w, input int pos);
`ifdef NEURAL_PARAM_CLAMP_EN
    int v;
    v = int'($signed(w));
    if (pos >= 2 && v > 256)  return 16'h0100;
    if (pos >= 2 && v < -256) return 16'hFF00;
`endif
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model advanced on each clock edge, cleared by async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial.delete();
      pending.delete();
      for (int i = 0; i < 10; i++) mact[i] = 16'h0000;
      mvalid = 1'b0;
    end else begin
      mcommit = 1'b0;
      macc    = wr_valid && (pending.size() == 0);
      if (clr) begin
        partial.delete();
        pending.delete();
      end else if (macc) begin
        partial.push_back(modelWord(wr_data, partial.size()));
        if (partial.size() == 10) begin
          if (!mvalid || out_ready) begin
            for (int i = 0; i < 10; i++) mframe[i] = partial[i];
            mcommit = 1'b1;
          end else begin
            pending = partial;
          end
          partial.delete();
        end
      end else if (pending.size() == 10 && out_ready) begin
        for (int i = 0; i < 10; i++) mframe[i] = pending[i];
        mcommit = 1'b1;
        pending.delete();
      end
      if (mcommit) begin
        for (int i = 0; i < 10; i++) mact[i] = mframe[i];
        mvalid = 1'b1;
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", 16'(out_valid), 16'(mvalid));
      checkOutput("wr_ready", 16'(wr_ready), 16'(pending.size() == 0));
      checkOutput("word_idx", 16'(word_idx), (pending.size() != 0) ? 16'd10 : 16'(partial.size()));
      checkOutput("in_a", in_a, mact[0]);
      checkOutput("in_b", in_b, mact[1]);
      checkOutput("c111", c111, mact[2]);
      checkOutput("c112", c112, mact[3]);
      checkOutput("c121", c121, mact[4]);
      checkOutput("c122", c122, mact[5]);
      checkOutput("c211", c211, mact[6]);
      checkOutput("c212", c212, mact[7]);
      checkOutput("c221", c221, mact[8]);
      checkOutput("c222", c222, mact[9]);
    end
  end

  // Drive one cycle of inputs and return just after the consuming edge
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c, input logic r);
    wr_valid  = v;
    wr_data   = d;
    clr       = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 16'h0000;
    clr       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_word_idx", 16'(word_idx), 16'd0);
    checkOutput("rst_wr_ready", 16'(wr_ready), 16'd1);
    checkOutput("rst_in_a", in_a, 16'h0000);
    checkOutput("rst_c222", c222, 16'h0000);

    // Single frame of 1.0 with nothing consuming
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
    checkOutput("f1_out_valid", 16'(out_valid), 16'd1);
    checkOutput("f1_in_a", in_a, 16'h0100);
    checkOutput("f1_c222", c222, 16'h0100);
    checkOutput("f1_wr_ready", 16'(wr_ready), 16'd1);
    checkOutput("f1_word_idx", 16'(word_idx), 16'd0);

    // Second frame of zeros parks in FULL
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    checkOutput("full_wr_ready", 16'(wr_ready), 16'd0);
    checkOutput("full_word_idx", 16'(word_idx), 16'd10);
    checkOutput("full_in_a", in_a, 16'h0100);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    checkOutput("full_hold_idx", 16'(word_idx), 16'd10);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_in_a", in_a, 16'h0000);
    checkOutput("bp_out_valid", 16'(out_valid), 16'd1);
    checkOutput("bp_wr_ready", 16'(wr_ready), 16'd1);
    checkOutput("bp_word_idx", 16'(word_idx), 16'd0);

    // Consume, then abort a partial frame and load a fresh one
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("consume_out_valid", 16'(out_valid), 16'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0);
    checkOutput("abort_pre_idx", 16'(word_idx), 16'd4);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("abort_idx", 16'(word_idx), 16'd0);
    checkOutput("abort_in_a", in_a, 16'h0000);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
    checkOutput("abort_c121", c121, 16'h0100);
    checkOutput("abort_in_a_new", in_a, 16'h0100);
    checkOutput("abort_out_valid", 16'(out_valid), 16'd1);

    // Commit and consume on the same edge
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1009, 1'b0, 1'b1);
    checkOutput("sim_out_valid", 16'(out_valid), 16'd1);
    checkOutput("sim_in_a", in_a, 16'h1000);
    checkOutput("sim_c222", c222, 16'h1009);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("sim_drop_valid", 16'(out_valid), 16'd0);

    // Clamp boundaries on weights; inputs pass through
    applyStimulus(1'b1, 16'h0300, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFE00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0300, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hF000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFF00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0);
    checkOutput("clamp_in_a", in_a, 16'h0300);
    checkOutput("clamp_in_b", in_b, 16'hFE00);
`ifdef NEURAL_PARAM_CLAMP_EN
    checkOutput("clamp_c111", c111, 16'h0100);
    checkOutput("clamp_c112", c112, 16'hFF00);
`else
    checkOutput("clamp_c111", c111, 16'h0300);
    checkOutput("clamp_c112", c112, 16'hF000);
`endif
    checkOutput("clamp_c121", c121, 16'h00FF);
    checkOutput("clamp_c122", c122, 16'hFF00);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b0);
    checkOutput("mid_word_idx", 16'(word_idx), 16'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_in_a", in_a, 16'h0000);
    checkOutput("arst_c111", c111, 16'h0000);
    checkOutput("arst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("arst_word_idx", 16'(word_idx), 16'd0);
    checkOutput("arst_wr_ready", 16'(wr_ready), 16'd1);
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    checkOutput("post_rst_in_a", in_a, 16'h2000);
    checkOutput("post_rst_in_b", in_b, 16'h2001);

    // Back-to-back frames with downstream always ready
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b1);
    checkOutput("b2b_out_valid", 16'(out_valid), 16'd1);
    checkOutput("b2b_word_idx", 16'(word_idx), 16'd0);

    // Abort a parked frame while the active one is consumed
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0);
    checkOutput("park_word_idx", 16'(word_idx), 16'd10);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("park_clr_valid", 16'(out_valid), 16'd0);
    checkOutput("park_clr_idx", 16'(word_idx), 16'd0);
    checkOutput("park_clr_ready", 16'(wr_ready), 16'd1);

    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
